// File: rtl/cla10_share_arb.sv
// cla10_share_arb: round-robin arbiter/sequencer sharing one CLA10 adder between two requesters.
module cla10 (
  input  logic [9:0] a_i,
  input  logic [9:0] b_i,
  input  logic       cin_i,
  output logic [9:0] sum_o,
  output logic       cout_o
);
  logic [9:0] g;
  logic [9:0] p;
  logic [10:0] c;
  logic pp;
  assign g = a_i & b_i;
  assign p = a_i ^ b_i;
  // Every carry is a flat sum-of-products of generates, propagates and cin.
  always_comb begin
    c = '0;
    pp = 1'b0;
    c[0] = cin_i;
    for (int i = 0; i < 10; i++) begin
      c[i+1] = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin_i);
    end
  end
  assign sum_o = p ^ c[9:0];
  assign cout_o = c[10];
endmodule

module cla10_share_arb #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_sum,
  output logic             rsp0_cout,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_sum,
  output logic             rsp1_cout,
  output logic             busy,
  output logic             last_grant
);
  if (WIDTH != 10) begin : g_width_err
    $error("cla10_share_arb: WIDTH must be 10");
  end
  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;
  state_t state_q, state_d;
  logic ptr_q, last_grant_q, id_q, cin_q, cout_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [WIDTH-1:0] add_sum;
  logic add_cout, win, hs, rsp_take;
  cla10 u_cla10 (
    .a_i   (a_q),
    .b_i   (b_q),
    .cin_i (cin_q),
    .sum_o (add_sum),
    .cout_o(add_cout)
  );
  // ptr only matters when both are valid; a lone requester always wins.
  assign win = (req0_valid & req1_valid) ? ptr_q : req1_valid;
  assign hs = !rst && state_q == IDLE && (req0_valid | req1_valid);
  assign req0_ready = hs & !win;
  assign req1_ready = hs & win;
  assign rsp_take = id_q ? rsp1_ready : rsp0_ready;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (hs ? ADD : IDLE) :
              (state_q == ADD) ? RESP :
              (state_q == RESP && !rsp_take) ? RESP : IDLE;
  end
  always_comb begin
    busy = state_q != IDLE;
    rsp0_valid = state_q == RESP && !id_q;
    rsp1_valid = state_q == RESP && id_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
      last_grant_q <= 1'b0;
      id_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      cin_q <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
    end else begin
      if (hs) begin
        a_q <= win ? req1_a : req0_a;
        b_q <= win ? req1_b : req0_b;
        cin_q <= win ? req1_cin : req0_cin;
        id_q <= win;
        ptr_q <= !win;
        last_grant_q <= win;
      end
      if (state_q == ADD) begin
        sum_q <= add_sum;
        cout_q <= add_cout;
      end
    end
  end
  assign last_grant = last_grant_q;
  assign rsp0_sum = sum_q;
  assign rsp1_sum = sum_q;
  assign rsp0_cout = cout_q;
  assign rsp1_cout = cout_q;
endmodule

// File: tb/tb_cla10_share_arb.sv
// tb_cla10_share_arb: directed stimulus with a result scoreboard for cla10_share_arb.
module tb_cla10_share_arb;
  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
  logic [9:0] req0_a, req0_b, req1_a, req1_b, rsp0_sum, rsp1_sum;
  logic rsp0_valid, rsp0_ready, rsp0_cout, rsp1_valid, rsp1_ready, rsp1_cout;
  logic busy, last_grant;
  typedef struct packed {logic id; logic cout; logic [9:0] sum;} exp_t;
  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cla10_share_arb dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum), .rsp0_cout(rsp0_cout),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum), .rsp1_cout(rsp1_cout),
    .busy(busy), .last_grant(last_grant)
  );

  function automatic exp_t model(input logic id, input logic [9:0] a, input logic [9:0] b, input logic cin);
    logic [10:0] r;
    r = {1'b0, a} + {1'b0, b} + {10'b0, cin};
    return exp_t'({id, r});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic neg();
    exp_t e;
    @(negedge clk);
    if (req0_valid && req0_ready) sbq.push_back(model(1'b0, req0_a, req0_b, req0_cin));
    if (req1_valid && req1_ready) sbq.push_back(model(1'b1, req1_a, req1_b, req1_cin));
    if (rsp0_valid || rsp1_valid) begin
      chk("rsp_one_hot", 32'(rsp0_valid & rsp1_valid), 32'(0));
      chk("rsp_pending", 32'(sbq.size() > 0), 32'(1));
      if (sbq.size() > 0) begin
        e = sbq[0];
        chk("rsp_id", 32'(rsp1_valid), 32'(e.id));
        chk("rsp_sum", 32'(e.id ? rsp1_sum : rsp0_sum), 32'(e.sum));
        chk("rsp_cout", 32'(e.id ? rsp1_cout : rsp0_cout), 32'(e.cout));
        if (e.id ? rsp1_ready : rsp0_ready) void'(sbq.pop_front());
      end
    end
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    neg();
    pos();
  endtask

  task automatic run_op(input logic id, input logic [9:0] a, input logic [9:0] b, input logic cin);
    exp_t e;
    e = model(id, a, b, cin);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    if (id) begin req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1; end
    else begin req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1; end
    neg();
    chk("op_accept", 32'(id ? req1_ready : req0_ready), 32'(1));
    pos();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    neg();
    chk("op_add_busy", 32'(busy), 32'(1));
    chk("op_add_norsp", 32'(rsp0_valid | rsp1_valid), 32'(0));
    pos();
    neg();
    chk("op_rsp_valid", 32'(id ? rsp1_valid : rsp0_valid), 32'(1));
    chk("op_rsp_other", 32'(id ? rsp0_valid : rsp1_valid), 32'(0));
    chk("op_sum", 32'(id ? rsp1_sum : rsp0_sum), 32'(e.sum));
    chk("op_cout", 32'(id ? rsp1_cout : rsp0_cout), 32'(e.cout));
    pos();
    neg();
    chk("op_idle", 32'(busy), 32'(0));
    pos();
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 10'd5; req0_b = 10'd7; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 10'd9; req1_b = 10'd1; req1_cin = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      neg();
      chk("rst_ready", 32'({req1_ready, req0_ready}), 32'(0));
      chk("rst_rsp", 32'({rsp1_valid, rsp0_valid}), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      pos();
    end
    rst = 1'b0;
    neg();
    chk("rel_grant", 32'({req1_ready, req0_ready}), 32'(2'b01));
    pos();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(); step(); step();
    // Single request; afterwards ptr points at requester 1.
    run_op(1'b0, 10'b1111101000, 10'b1111000000, 1'b0);
    // Backpressure: both valid, ptr picks req1, whose response is then held.
    req0_a = 10'b0011100000; req0_b = 10'b1001000000; req0_cin = 1'b0; req0_valid = 1'b1;
    req1_a = 10'b1111101000; req1_b = 10'b1111000100; req1_cin = 1'b0; req1_valid = 1'b1;
    rsp1_ready = 1'b0;
    neg();
    chk("bp_grant", 32'({req1_ready, req0_ready}), 32'(2'b10));
    pos();
    req1_valid = 1'b0;
    neg();
    chk("bp_add_busy", 32'(busy), 32'(1));
    chk("bp_add_r0", 32'(req0_ready), 32'(0));
    pos();
    for (int k = 0; k < 5; k++) begin
      neg();
      chk("bp_valid", 32'(rsp1_valid), 32'(1));
      chk("bp_sum", 32'(rsp1_sum), 32'(10'b1110101100));
      chk("bp_cout", 32'(rsp1_cout), 32'(1));
      chk("bp_busy", 32'(busy), 32'(1));
      chk("bp_r0", 32'(req0_ready), 32'(0));
      pos();
    end
    rsp1_ready = 1'b1;
    neg();
    chk("bp_take", 32'(rsp1_valid), 32'(1));
    pos();
    // Contention follows immediately with ptr back at 0.
    req1_a = 10'b1100001000; req1_b = 10'b1011000000; req1_cin = 1'b0; req1_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      neg();
      if (k == 0) chk("bp_idle", 32'(busy), 32'(0));
      if (k % 3 == 0) chk("ct_grant", 32'({req1_ready, req0_ready}), 32'(((k / 3) % 2) ? 2'b10 : 2'b01));
      else chk("ct_noready", 32'({req1_ready, req0_ready}), 32'(0));
      if (k % 3 == 1) chk("ct_last", 32'(last_grant), 32'((k / 3) % 2));
      if (k % 3 == 2) chk("ct_sum", 32'(((k / 3) % 2) ? rsp1_sum : rsp0_sum),
                          32'(((k / 3) % 2) ? 10'b0111001000 : 10'b1100100000));
      if (k % 3 == 2) chk("ct_cout", 32'(((k / 3) % 2) ? rsp1_cout : rsp0_cout), 32'((k / 3) % 2));
      pos();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    run_op(1'b0, 10'b1111111111, 10'b0000000000, 1'b1);
    run_op(1'b1, 10'b0000000000, 10'b0000000000, 1'b0);
    // Reset while the req1 operation sits in ADD.
    req1_a = 10'd3; req1_b = 10'd4; req1_cin = 1'b0; req1_valid = 1'b1;
    neg();
    chk("mid_accept", 32'(req1_ready), 32'(1));
    pos();
    req1_valid = 1'b0;
    rst = 1'b1;
    neg();
    chk("mid_add_norsp", 32'({rsp1_valid, rsp0_valid}), 32'(0));
    pos();
    rst = 1'b0;
    sbq.delete();
    req0_valid = 1'b1; req1_valid = 1'b1;
    neg();
    chk("mid_ptr", 32'({req1_ready, req0_ready}), 32'(2'b01));
    chk("mid_busy", 32'(busy), 32'(0));
    chk("mid_last", 32'(last_grant), 32'(0));
    pos();
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      neg();
      chk("mid_no_rsp1", 32'(rsp1_valid), 32'(0));
      pos();
    end
    chk("sb_empty", 32'(sbq.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
